// File: rtl/heap_pq_gen_if.sv
// Command/status bundle for heap_pq_gen: flat valid/ready command port plus
// root/occupancy status and the error pulse.
interface heap_pq_gen_if #(
  parameter int KEY_W    = 16,
  parameter int VAL_W    = 16,
  parameter int CAPACITY = 15
);
  localparam int CW = $clog2(CAPACITY + 1);

  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [KEY_W-1:0] cmd_key;
  logic [VAL_W-1:0] cmd_val;
  logic             cmd_ready;
  logic [KEY_W-1:0] top_key;
  logic [VAL_W-1:0] top_val;
  logic             top_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_val,
    input  cmd_ready, top_key, top_val, top_valid, count, full, empty, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_val,
    output cmd_ready, top_key, top_val, top_valid, count, full, empty, err
  );
endinterface

// File: rtl/heap_pq_gen.sv
// Parametrised binary-heap priority queue over a single-port, synchronous-read
// array indexed 1..CAPACITY; one memory access per cycle drives the FSM timing.
module heap_pq_gen #(
  parameter int KEY_W    = 16,
  parameter int VAL_W    = 16,
  parameter int CAPACITY = 15,
  parameter int MAX_HEAP = 0
) (
  input logic          clk,
  input logic          rst_n,
  heap_pq_gen_if.slave bus
);
  localparam int CW   = $clog2(CAPACITY + 1);
  localparam int KV_W = KEY_W + VAL_W;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);
  localparam logic [1:0] OP_ENQ = 2'b01;
  localparam logic [1:0] OP_DEQ = 2'b10;
  localparam logic [1:0] OP_RPL = 2'b11;

  if (CAPACITY < 1 || ((CAPACITY & (CAPACITY + 1)) != 0)) begin : g_cap_chk
    $fatal(1, "heap_pq_gen: CAPACITY must be 2**L-1");
  end

  typedef enum logic [3:0] {
    IDLE, ENQ_WR, ENQ_RDP, ENQ_CMP, ENQ_SWP2, DEQ_RD, DEQ_WR, RPL_WR,
    HP_RDL, HP_RDR, HP_SWP, HP_SWP2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d, idx_q, idx_d, m_q, m_d;
  logic [KV_W-1:0]   kv_q, kv_d, tmp_q, tmp_d;
  logic              rd_r_q, rd_r_d, err_q, err_d, ready_q, ready_d;
  logic [KEY_W-1:0]  top_key_q, top_key_d;
  logic [VAL_W-1:0]  top_val_q, top_val_d;

  logic [KV_W-1:0]   mem [CAPACITY+1];
  logic [KV_W-1:0]   mem_rdata;
  logic              mem_we, mem_re;
  logic [CW-1:0]     mem_addr;
  logic [KV_W-1:0]   mem_din;

  logic [CW:0]       left, right, cnt_ext;
  logic [CW-1:0]     m_f;
  logic [KV_W-1:0]   mkv_f;
  logic              is_full, is_empty;

  function automatic logic [KEY_W-1:0] key_of(input logic [KV_W-1:0] kv);
    return kv[KV_W-1 -: KEY_W];
  endfunction

  function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    return (MAX_HEAP != 0) ? (a > b) : (a < b);
  endfunction

  assign left     = {idx_q, 1'b0};
  assign right    = {idx_q, 1'b1};
  assign cnt_ext  = {1'b0, count_q};
  assign is_full  = (count_q == CAP_C);
  assign is_empty = (count_q == '0);

  always_ff @(posedge clk) begin
    if (mem_we)      mem[mem_addr] <= mem_din;
    else if (mem_re) mem_rdata     <= mem[mem_addr];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    m_d       = m_q;
    kv_d      = kv_q;
    tmp_d     = tmp_q;
    rd_r_d    = rd_r_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_din   = kv_q;
    m_f       = m_q;
    mkv_f     = tmp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          unique case (bus.cmd_op)
            OP_ENQ: begin
              if (is_full) err_d = 1'b1;
              else begin
                kv_d    = {bus.cmd_key, bus.cmd_val};
                state_d = ENQ_WR;
              end
            end
            OP_DEQ: begin
              if (is_empty) err_d = 1'b1;
              else state_d = DEQ_RD;
            end
            OP_RPL: begin
              kv_d    = {bus.cmd_key, bus.cmd_val};
              state_d = is_empty ? ENQ_WR : RPL_WR;
            end
            default: ;
          endcase
        end
      end
      ENQ_WR: begin
        count_d  = count_q + ONE;
        idx_d    = count_q + ONE;
        mem_we   = 1'b1;
        mem_addr = count_q + ONE;
        state_d  = (count_q == '0) ? IDLE : ENQ_RDP;
      end
      ENQ_RDP: begin
        mem_re   = 1'b1;
        mem_addr = idx_q >> 1;
        state_d  = ENQ_CMP;
      end
      ENQ_CMP: begin
        if (better(key_of(kv_q), key_of(mem_rdata))) begin
          mem_we   = 1'b1;
          mem_addr = idx_q >> 1;
          tmp_d    = mem_rdata;
          state_d  = ENQ_SWP2;
        end else begin
          state_d  = IDLE;
        end
      end
      ENQ_SWP2: begin
        mem_we   = 1'b1;
        mem_addr = idx_q;
        mem_din  = tmp_q;
        idx_d    = idx_q >> 1;
        state_d  = ((idx_q >> 1) == ONE) ? IDLE : ENQ_RDP;
      end
      DEQ_RD: begin
        mem_re   = 1'b1;
        mem_addr = count_q;
        count_d  = count_q - ONE;
        state_d  = DEQ_WR;
      end
      DEQ_WR: begin
        if (count_q == '0) begin
          state_d  = IDLE;
        end else begin
          mem_we   = 1'b1;
          mem_addr = ONE;
          mem_din  = mem_rdata;
          kv_d     = mem_rdata;
          idx_d    = ONE;
          state_d  = HP_RDL;
        end
      end
      RPL_WR: begin
        mem_we   = 1'b1;
        mem_addr = ONE;
        idx_d    = ONE;
        state_d  = HP_RDL;
      end
      HP_RDL: begin
        if (left > cnt_ext) state_d = IDLE;
        else begin
          mem_re   = 1'b1;
          mem_addr = left[CW-1:0];
          state_d  = HP_RDR;
        end
      end
      // tmp holds the best candidate seen so far, m its index
      HP_RDR: begin
        if (better(key_of(mem_rdata), key_of(kv_q))) begin
          m_d   = left[CW-1:0];
          tmp_d = mem_rdata;
        end else begin
          m_d   = idx_q;
          tmp_d = kv_q;
        end
        rd_r_d = (right <= cnt_ext);
        if (right <= cnt_ext) begin
          mem_re   = 1'b1;
          mem_addr = right[CW-1:0];
        end
        state_d = HP_SWP;
      end
      HP_SWP: begin
        if (rd_r_q && better(key_of(mem_rdata), key_of(tmp_q))) begin
          m_f   = right[CW-1:0];
          mkv_f = mem_rdata;
        end
        if (m_f == idx_q) state_d = IDLE;
        else begin
          mem_we   = 1'b1;
          mem_addr = idx_q;
          mem_din  = mkv_f;
          m_d      = m_f;
          state_d  = HP_SWP2;
        end
      end
      HP_SWP2: begin
        mem_we   = 1'b1;
        mem_addr = m_q;
        idx_d    = m_q;
        state_d  = HP_RDL;
      end
      default: state_d = IDLE;
    endcase

    top_key_d = top_key_q;
    top_val_d = top_val_q;
    if (mem_we && mem_addr == ONE) {top_key_d, top_val_d} = mem_din;
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      m_q       <= '0;
      kv_q      <= '0;
      tmp_q     <= '0;
      rd_r_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      top_key_q <= '0;
      top_val_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      m_q       <= m_d;
      kv_q      <= kv_d;
      tmp_q     <= tmp_d;
      rd_r_q    <= rd_r_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      top_key_q <= top_key_d;
      top_val_q <= top_val_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.top_key   = top_key_q;
  assign bus.top_val   = top_val_q;
  assign bus.top_valid = !is_empty;
  assign bus.count     = count_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_heap_pq_gen.sv
// Scoreboarded bench for heap_pq_gen: three instances (min/15, max/15, min/31 8-bit keys)
// checked against an unordered-multiset reference model.
module tb_heap_pq_gen;
  localparam int ND = 3;
  localparam logic [1:0] OP_NOP = 2'b00, OP_ENQ = 2'b01, OP_DEQ = 2'b10, OP_RPL = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          cap   [ND] = '{15, 15, 31};
  bit          maxh  [ND] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] kmask [ND] = '{16'hFFFF, 16'hFFFF, 16'h00FF};

  logic        v  [ND];
  logic [1:0]  op [ND];
  logic [15:0] ck [ND];
  logic [15:0] cv [ND];
  wire         o_rdy [ND];
  wire         o_tv [ND];
  wire         o_full [ND];
  wire         o_empty [ND];
  wire         o_err [ND];
  wire  [15:0] o_key [ND];
  wire  [15:0] o_val [ND];
  wire  [7:0]  o_cnt [ND];

  heap_pq_gen_if #(.KEY_W(16), .VAL_W(16), .CAPACITY(15)) if0 ();
  heap_pq_gen_if #(.KEY_W(16), .VAL_W(16), .CAPACITY(15)) if1 ();
  heap_pq_gen_if #(.KEY_W(8),  .VAL_W(16), .CAPACITY(31)) if2 ();

  assign if0.cmd_valid = v[0];  assign if0.cmd_op = op[0];
  assign if0.cmd_key = ck[0];   assign if0.cmd_val = cv[0];
  assign if1.cmd_valid = v[1];  assign if1.cmd_op = op[1];
  assign if1.cmd_key = ck[1];   assign if1.cmd_val = cv[1];
  assign if2.cmd_valid = v[2];  assign if2.cmd_op = op[2];
  assign if2.cmd_key = ck[2][7:0]; assign if2.cmd_val = cv[2];

  assign o_rdy[0] = if0.cmd_ready; assign o_tv[0] = if0.top_valid; assign o_full[0] = if0.full;
  assign o_empty[0] = if0.empty;   assign o_err[0] = if0.err;      assign o_key[0] = if0.top_key;
  assign o_val[0] = if0.top_val;   assign o_cnt[0] = {4'b0, if0.count};
  assign o_rdy[1] = if1.cmd_ready; assign o_tv[1] = if1.top_valid; assign o_full[1] = if1.full;
  assign o_empty[1] = if1.empty;   assign o_err[1] = if1.err;      assign o_key[1] = if1.top_key;
  assign o_val[1] = if1.top_val;   assign o_cnt[1] = {4'b0, if1.count};
  assign o_rdy[2] = if2.cmd_ready; assign o_tv[2] = if2.top_valid; assign o_full[2] = if2.full;
  assign o_empty[2] = if2.empty;   assign o_err[2] = if2.err;      assign o_key[2] = {8'b0, if2.top_key};
  assign o_val[2] = if2.top_val;   assign o_cnt[2] = {3'b0, if2.count};

  heap_pq_gen #(.KEY_W(16), .VAL_W(16), .CAPACITY(15), .MAX_HEAP(0))
    u_min (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  heap_pq_gen #(.KEY_W(16), .VAL_W(16), .CAPACITY(15), .MAX_HEAP(1))
    u_max (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  heap_pq_gen #(.KEY_W(8), .VAL_W(16), .CAPACITY(31), .MAX_HEAP(0))
    u_big (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Reference model: unordered multiset per instance; kn=0 once a tie made the payload ambiguous
  typedef struct packed { logic [15:0] k; logic [15:0] v; logic kn; } ent_t;
  ent_t mdl [ND][32];
  int   mcnt [ND];

  typedef struct { int d; bit err; int cnt; bit kchk; logic [15:0] k; bit vchk; logic [15:0] v; } exp_t;
  exp_t sbq [$];

  int n_vec = 0, n_err = 0;
  bit pend [ND];
  bit errs [ND];
  bit mon_en;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic bit bet(input int d, input logic [15:0] a, input logic [15:0] b);
    return maxh[d] ? (a > b) : (a < b);
  endfunction

  function automatic int best_idx(input int d);
    int bi = 0;
    for (int i = 1; i < mcnt[d]; i++)
      if (bet(d, mdl[d][i].k, mdl[d][bi].k)) bi = i;
    return bi;
  endfunction

  task automatic m_add(input int d, input logic [15:0] k, input logic [15:0] val);
    mdl[d][mcnt[d]] = '{k: k, v: val, kn: 1'b1};
    mcnt[d]++;
  endtask

  task automatic m_remove(input int d);
    int bi, n;
    logic [15:0] k;
    bi = best_idx(d);
    k  = mdl[d][bi].k;
    n  = 0;
    for (int i = 0; i < mcnt[d]; i++) if (mdl[d][i].k == k) n++;
    mdl[d][bi] = mdl[d][mcnt[d]-1];
    mcnt[d]--;
    if (n > 1)
      for (int i = 0; i < mcnt[d]; i++) if (mdl[d][i].k == k) mdl[d][i].kn = 1'b0;
  endtask

  task automatic issue(input int d, input logic [1:0] o, input logic [15:0] k_in, input logic [15:0] val);
    exp_t e;
    logic [15:0] k;
    int bi, n;
    bit done;
    k = k_in & kmask[d];
    e.d = d; e.err = 1'b0;
    case (o)
      OP_ENQ: if (mcnt[d] == cap[d]) e.err = 1'b1; else m_add(d, k, val);
      OP_DEQ: if (mcnt[d] == 0) e.err = 1'b1; else m_remove(d);
      OP_RPL: begin if (mcnt[d] != 0) m_remove(d); m_add(d, k, val); end
      default: ;
    endcase
    e.cnt = mcnt[d]; e.kchk = 1'b0; e.vchk = 1'b0; e.k = '0; e.v = '0;
    if (mcnt[d] > 0) begin
      bi = best_idx(d);
      e.kchk = 1'b1; e.k = mdl[d][bi].k; e.v = mdl[d][bi].v;
      n = 0;
      for (int i = 0; i < mcnt[d]; i++) if (mdl[d][i].k == e.k) n++;
      e.vchk = (n == 1) && mdl[d][bi].kn;
    end
    sbq.push_back(e);

    @(posedge clk); #1;
    v[d] = 1'b1; op[d] = o; ck[d] = k; cv[d] = val;
    @(posedge clk); #1;
    v[d] = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk); #1;
      if (!pend[d]) done = 1'b1;
    end
    if (!done) begin
      $display("FAIL timeout dut%0d: cmd_ready did not return within 60 cycles", d);
      $fatal(1, "bench aborted");
    end
  endtask

  task automatic check(input int d);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", d, 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    chk("cmd_route", d, d, e.d);
    chk("err", d, {31'b0, errs[d]}, {31'b0, e.err});
    chk("count", d, {24'b0, o_cnt[d]}, e.cnt);
    chk("top_valid", d, {31'b0, o_tv[d]}, {31'b0, e.cnt != 0});
    chk("full", d, {31'b0, o_full[d]}, {31'b0, e.cnt == cap[d]});
    chk("empty", d, {31'b0, o_empty[d]}, {31'b0, e.cnt == 0});
    if (e.kchk) chk("top_key", d, {16'b0, o_key[d]}, {16'b0, e.k});
    if (e.vchk) chk("top_val", d, {16'b0, o_val[d]}, {16'b0, e.v});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < ND; d++) begin
        if (pend[d]) begin
          errs[d] = errs[d] | o_err[d];
          if (o_rdy[d]) begin
            check(d);
            pend[d] = 1'b0;
          end
        end else if (v[d] && o_rdy[d]) begin
          pend[d] = 1'b1;
          errs[d] = 1'b0;
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_ready"}, d, {31'b0, o_rdy[d]}, 32'd1);
      chk({tag, "_count"}, d, {24'b0, o_cnt[d]}, 32'd0);
      chk({tag, "_key"},   d, {16'b0, o_key[d]}, 32'd0);
      chk({tag, "_val"},   d, {16'b0, o_val[d]}, 32'd0);
      chk({tag, "_err"},   d, {31'b0, o_err[d]}, 32'd0);
      chk({tag, "_empty"}, d, {31'b0, o_empty[d]}, 32'd1);
    end
  endtask

  logic [15:0] popk [4];
  logic [15:0] popv [4];
  logic [15:0] exp_pk [4] = '{16'd8, 16'd8, 16'd5, 16'd3};
  logic [15:0] k1 [4] = '{16'd9, 16'd4, 16'd7, 16'd1};

  initial begin
    for (int d = 0; d < ND; d++) begin
      v[d] = 1'b0; op[d] = OP_NOP; ck[d] = '0; cv[d] = '0;
      mcnt[d] = 0; pend[d] = 1'b0; errs[d] = 1'b0;
    end
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    reset_checks("rst");

    // min-heap basic enqueue / dequeue, including empty dequeue error
    for (int i = 0; i < 4; i++) issue(0, OP_ENQ, k1[i], 16'h1000 + k1[i]);
    for (int i = 0; i < 5; i++) issue(0, OP_DEQ, 16'd0, 16'd0);

    // fill to capacity, reject overflow, replace at full
    for (int k = 15; k >= 1; k--) issue(0, OP_ENQ, 16'(k), 16'h2000 + 16'(k));
    issue(0, OP_ENQ, 16'd0, 16'h2FFF);
    issue(0, OP_RPL, 16'd20, 16'h2020);

    // max-heap with duplicate keys; replace on empty behaves as enqueue
    issue(1, OP_RPL, 16'd77, 16'h0077);
    issue(1, OP_DEQ, 16'd0, 16'd0);
    issue(1, OP_ENQ, 16'd3, 16'h0030);
    issue(1, OP_ENQ, 16'd8, 16'h0081);
    issue(1, OP_ENQ, 16'd8, 16'h0082);
    issue(1, OP_ENQ, 16'd5, 16'h0050);
    for (int j = 0; j < 4; j++) begin
      popk[j] = o_key[1];
      popv[j] = o_val[1];
      issue(1, OP_DEQ, 16'd0, 16'd0);
    end
    for (int j = 0; j < 4; j++) chk("pop_key", 1, {16'b0, popk[j]}, {16'b0, exp_pk[j]});
    chk("tie_payloads", 1,
        {31'b0, (popv[0] == 16'h0081 && popv[1] == 16'h0082) ||
                (popv[0] == 16'h0082 && popv[1] == 16'h0081)}, 32'd1);
    chk("pop_val5", 1, {16'b0, popv[2]}, 32'h0050);
    chk("pop_val3", 1, {16'b0, popv[3]}, 32'h0030);

    // randomized traffic alternating fill-heavy and drain-heavy phases
    for (int d = 1; d < ND; d++) begin
      int nops = (d == 2) ? 1500 : 700;
      for (int i = 0; i < nops; i++) begin
        int r = $urandom_range(0, 99);
        bit fill = ((i / 150) % 2) == 0;
        logic [1:0] o;
        logic [15:0] k = (d == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        if (fill) o = (r < 55) ? OP_ENQ : (r < 75) ? OP_DEQ : (r < 95) ? OP_RPL : OP_NOP;
        else      o = (r < 25) ? OP_ENQ : (r < 70) ? OP_DEQ : (r < 90) ? OP_RPL : OP_NOP;
        issue(d, o, k, 16'($urandom));
      end
    end

    // asynchronous reset in the middle of a sift-down
    mon_en = 1'b0;
    @(posedge clk); #1;
    v[0] = 1'b1; op[0] = OP_DEQ;
    @(posedge clk); #1;
    v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("busy_mid_deq", 0, {31'b0, o_rdy[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 0, {24'b0, o_cnt[0]}, 32'd0);
    chk("arst_key", 0, {16'b0, o_key[0]}, 32'd0);
    chk("arst_val", 0, {16'b0, o_val[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_checks("post_arst");
    sbq.delete();
    for (int d = 0; d < ND; d++) begin mcnt[d] = 0; pend[d] = 1'b0; end
    mon_en = 1'b1;
    issue(0, OP_ENQ, 16'd42, 16'h4242);
    issue(0, OP_ENQ, 16'd41, 16'h4141);
    issue(0, OP_DEQ, 16'd0, 16'd0);

    chk("sb_drained", 0, sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
